mc_controller: RTL

- Multi-cycle control unit sitting directly upstream of the single-cycle MIPS datapath.
- Decodes the fetched instruction and sequences the datapath's existing control inputs over several cycles. The control inputs are Wreg_sel, Wdata_sel, W_en, ALUop, ALUsrc, DM_sel, DM_en, Branch, EXT_sel and Shift_sel.
- Adds IR_en and PC_en strobes so PC, register-file and memory updates happen exactly once per instruction.
- Keeps a retired-instruction counter and flags illegal opcodes.

---
 rtl/mc_controller_if.sv | 34 +++
 rtl/mc_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mc_controller_if.sv
// Control bundle between mc_controller and the single-cycle MIPS datapath.
// The controller drives everything except the fetched instruction word.
interface mc_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      instruction;
  logic             IR_en;
  logic             PC_en;
  logic [1:0]       Wreg_sel;
  logic [1:0]       Wdata_sel;
  logic             W_en;
  logic [1:0]       ALUop;
  logic             ALUsrc;
  logic             DM_sel;
  logic             DM_en;
  logic             Branch;
  logic             EXT_sel;
  logic             Shift_sel;
  logic             illegal;
  logic             instr_done;
  logic [CNT_W-1:0] retired;

  modport master (
    input  instruction,
    output IR_en, PC_en, Wreg_sel, Wdata_sel, W_en, ALUop, ALUsrc,
           DM_sel, DM_en, Branch, EXT_sel, Shift_sel, illegal, instr_done, retired
  );

  modport slave (
    output instruction,
    input  IR_en, PC_en, Wreg_sel, Wdata_sel, W_en, ALUop, ALUsrc,
           DM_sel, DM_en, Branch, EXT_sel, Shift_sel, illegal, instr_done, retired
  );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle control unit for the MIPS datapath: FETCH/DECODE/EXEC/MEM/WB
// sequencing with registered Moore outputs, retired counter and illegal flag.
module mc_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  mc_controller_if.master bus
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

  typedef enum logic [3:0] {
    C_NOP, C_ADDU, C_SUBU, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_ILL
  } cls_t;

  typedef struct packed {
    logic       ir_en;
    logic       pc_en;
    logic [1:0] wreg_sel;
    logic [1:0] wdata_sel;
    logic       w_en;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       dm_sel;
    logic       dm_en;
    logic       branch;
    logic       ext_sel;
    logic       shift_sel;
    logic       illegal;
    logic       instr_done;
  } ctl_t;

  state_t           state;
  logic [31:0]      ir;
  logic [CNT_W-1:0] retired_q;
  logic             run;
  ctl_t             out_q;

  cls_t             cur_cls;
  state_t           nxt_state;
  ctl_t             nxt_ctl;

  function automatic cls_t classify(input logic [31:0] w);
    cls_t c;
    c = C_ILL;
    case (w[31:26])
      6'b000000: begin
        if (w == '0)                  c = C_NOP;
        else if (w[5:0] == 6'b100001) c = C_ADDU;
        else if (w[5:0] == 6'b100011) c = C_SUBU;
        else                          c = C_ILL;
      end
      6'b001101: c = C_ORI;
      6'b100011: c = C_LW;
      6'b101011: c = C_SW;
      6'b000100: c = C_BEQ;
      6'b001111: c = C_LUI;
      default:   c = C_ILL;
    endcase
    return c;
  endfunction

  function automatic state_t next_of(input state_t s, input cls_t c);
    state_t n;
    n = FETCH;
    case (s)
      FETCH:  n = DECODE;
      DECODE: n = (c == C_NOP || c == C_ILL) ? FETCH : EXEC;
      EXEC: begin
        case (c)
          C_BEQ:      n = FETCH;
          C_LW, C_SW: n = MEM;
          default:    n = WB;
        endcase
      end
      MEM:     n = (c == C_LW) ? WB : FETCH;
      default: n = FETCH;
    endcase
    return n;
  endfunction

  // Selects are asserted from EXEC onward and held until the instruction ends;
  // the strobes pick out the single terminal cycle of each sequence.
  function automatic ctl_t ctl_of(input state_t s, input cls_t c);
    ctl_t o;
    o = '0;
    if (s == EXEC || s == MEM || s == WB) begin
      case (c)
        C_ADDU: begin
          o.alu_op = 2'd0; o.alu_src = 1'b0; o.wreg_sel = 2'd1; o.wdata_sel = 2'd0;
        end
        C_SUBU: begin
          o.alu_op = 2'd1; o.alu_src = 1'b0; o.wreg_sel = 2'd1; o.wdata_sel = 2'd0;
        end
        C_ORI: begin
          o.alu_op = 2'd2; o.alu_src = 1'b1; o.ext_sel = 1'b0;
          o.wreg_sel = 2'd0; o.wdata_sel = 2'd0;
        end
        C_LW: begin
          o.alu_op = 2'd0; o.alu_src = 1'b1; o.ext_sel = 1'b1;
          o.wreg_sel = 2'd0; o.wdata_sel = 2'd1;
        end
        C_SW: begin
          o.alu_op = 2'd0; o.alu_src = 1'b1; o.ext_sel = 1'b1;
        end
        C_BEQ: begin
          o.alu_op = 2'd1; o.alu_src = 1'b0; o.ext_sel = 1'b1; o.shift_sel = 1'b0;
        end
        C_LUI: begin
          o.ext_sel = 1'b0; o.shift_sel = 1'b1; o.wreg_sel = 2'd0; o.wdata_sel = 2'd2;
        end
        default: o = '0;
      endcase
    end
    case (s)
      FETCH: o.ir_en = 1'b1;
      DECODE: begin
        if (c == C_NOP || c == C_ILL) begin
          o.pc_en      = 1'b1;
          o.instr_done = 1'b1;
        end
        o.illegal = (c == C_ILL);
      end
      EXEC: begin
        if (c == C_BEQ) begin
          o.branch     = 1'b1;
          o.pc_en      = 1'b1;
          o.instr_done = 1'b1;
        end
      end
      MEM: begin
        if (c == C_SW) begin
          o.dm_en      = 1'b1;
          o.pc_en      = 1'b1;
          o.instr_done = 1'b1;
        end
      end
      WB: begin
        o.w_en       = 1'b1;
        o.pc_en      = 1'b1;
        o.instr_done = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Outputs are registered alongside the state, so the DECODE-cycle outputs
  // are classified from the word being latched into IR on the same edge.
  always_comb begin
    cur_cls   = (state == FETCH) ? classify(bus.instruction) : classify(ir);
    nxt_state = next_of(state, cur_cls);
    nxt_ctl   = ctl_of(nxt_state, cur_cls);
  end

  // run holds off the first FETCH by one cycle so every output is quiet
  // in the cycle following reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      ir        <= '0;
      retired_q <= '0;
      run       <= 1'b0;
      out_q     <= '0;
    end else if (!run) begin
      run   <= 1'b1;
      state <= FETCH;
      out_q <= ctl_of(FETCH, C_NOP);
    end else begin
      if (state == FETCH) ir <= bus.instruction;
      state <= nxt_state;
      out_q <= nxt_ctl;
      if (nxt_ctl.instr_done) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.IR_en      = out_q.ir_en;
  assign bus.PC_en      = out_q.pc_en;
  assign bus.Wreg_sel   = out_q.wreg_sel;
  assign bus.Wdata_sel  = out_q.wdata_sel;
  assign bus.W_en       = out_q.w_en;
  assign bus.ALUop      = out_q.alu_op;
  assign bus.ALUsrc     = out_q.alu_src;
  assign bus.DM_sel     = out_q.dm_sel;
  assign bus.DM_en      = out_q.dm_en;
  assign bus.Branch     = out_q.branch;
  assign bus.EXT_sel    = out_q.ext_sel;
  assign bus.Shift_sel  = out_q.shift_sel;
  assign bus.illegal    = out_q.illegal;
  assign bus.instr_done = out_q.instr_done;
  assign bus.retired    = retired_q;

endmodule
